// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) with parity, framing and line-break reporting.
// Optional build macro UART_RX_MAJORITY_EN: every sample point uses a 2-of-3
// majority vote over the last three synchronised line samples (needs
// CLKS_PER_BIT >= 6). Without it a single synchronised sample is used.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_BIT  = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_CLEANUP,
        S_WAIT_IDLE
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic                   rx_sample;
    logic [CW-1:0]          clk_cnt;
    logic [3:0]             bit_idx;
    logic [DATA_BITS-1:0]   data_reg;
    logic                   par_acc;
    logic                   par_err_acc;
    logic                   frame_acc;
    logic                   any_one;

    // Two-flop synchroniser; both stages reset to the idle (high) level.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;

    // History of the two previous synced samples; with rx_sync it forms the vote window.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_hist <= 2'b11;
        end else begin
            rx_hist <= {rx_hist[0], rx_sync};
        end
    end

    assign rx_sample = (rx_hist[1] & rx_hist[0]) |
                       (rx_hist[1] & rx_sync)    |
                       (rx_hist[0] & rx_sync);
`else
    assign rx_sample = rx_sync;
`endif

    // Receive FSM: mid-bit sampling, flag accumulation and registered outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state        <= S_IDLE;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            data_reg     <= '0;
            par_acc      <= 1'b0;
            par_err_acc  <= 1'b0;
            frame_acc    <= 1'b0;
            any_one      <= 1'b0;
            o_Rx_DV      <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
            o_Busy       <= 1'b0;
        end else begin
            o_Rx_DV <= 1'b0;
            case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (!rx_sync) begin
                        // The detecting cycle already counts as the first start-bit tick.
                        state   <= S_START;
                        clk_cnt <= CW'(1);
                        o_Busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (clk_cnt == HALF_BIT) begin
                        if (!rx_sample) begin
                            state       <= S_DATA;
                            clk_cnt     <= '0;
                            bit_idx     <= '0;
                            par_acc     <= 1'b0;
                            par_err_acc <= 1'b0;
                            frame_acc   <= 1'b0;
                            any_one     <= 1'b0;
                        end else begin
                            state  <= S_IDLE;
                            o_Busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == LAST_TICK) begin
                        clk_cnt  <= '0;
                        data_reg <= {rx_sample, data_reg[DATA_BITS-1:1]};
                        par_acc  <= par_acc ^ rx_sample;
                        any_one  <= any_one | rx_sample;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (clk_cnt == LAST_TICK) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        any_one <= any_one | rx_sample;
                        if (PARITY == 1) begin
                            par_err_acc <= ~(par_acc ^ rx_sample);
                        end else begin
                            par_err_acc <= par_acc ^ rx_sample;
                        end
                        state <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == LAST_TICK) begin
                        clk_cnt <= '0;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx      <= '0;
                            o_Rx_DV      <= 1'b1;
                            o_Rx_Byte    <= data_reg;
                            o_Parity_Err <= par_err_acc;
                            o_Frame_Err  <= frame_acc | ~rx_sample;
                            o_Break      <= ~(any_one | rx_sample);
                            state        <= (frame_acc | ~rx_sample) ? S_WAIT_IDLE : S_CLEANUP;
                        end else begin
                            bit_idx   <= bit_idx + 4'd1;
                            frame_acc <= frame_acc | ~rx_sample;
                            any_one   <= any_one | rx_sample;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_CLEANUP: begin
                    state  <= S_IDLE;
                    o_Busy <= 1'b0;
                end
                S_WAIT_IDLE: begin
                    if (rx_sync) begin
                        state  <= S_IDLE;
                        o_Busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param. Two instances are
// exercised: dut_a (8N1) and dut_b (7 data bits, even parity, 2 stop bits),
// both at 16 clocks per bit. Honours UART_RX_MAJORITY_EN for the spike test.
module tb_uart_rx_param;

    localparam int C = 16;
    localparam int H = (C - 1) / 2;

    logic clk = 1'b0;
    int   cyc = 0;

    logic       rst_a, rst_b, rx_a, rx_b;
    logic       dv_a, perr_a, ferr_a, brk_a, busy_a;
    logic       dv_b, perr_b, ferr_b, brk_b, busy_b;
    logic [7:0] byte_a;
    logic [6:0] byte_b;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         t;
    } dv_rec_t;

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       pbit;
        logic [1:0] stops;
        logic [8:0] exp_byte;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    dv_rec_t rec_a[$];
    dv_rec_t rec_b[$];
    int      errors = 0;
    int      checks = 0;

    // Free-running clock and cycle counter (counts rising edges).
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .i_Clock(clk), .i_Reset(rst_a), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a),
        .o_Rx_Byte(byte_a), .o_Parity_Err(perr_a), .o_Frame_Err(ferr_a),
        .o_Break(brk_a), .o_Busy(busy_a)
    );

    uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
        .i_Clock(clk), .i_Reset(rst_b), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b),
        .o_Rx_Byte(byte_b), .o_Parity_Err(perr_b), .o_Frame_Err(ferr_b),
        .o_Break(brk_b), .o_Busy(busy_b)
    );

    // Record every DV pulse, sampled on the falling edge away from the active edge.
    always @(negedge clk) begin
        if (dv_a === 1'b1) rec_a.push_back('{9'(byte_a), perr_a, ferr_a, brk_a, cyc});
        if (dv_b === 1'b1) rec_b.push_back('{9'(byte_b), perr_b, ferr_b, brk_b, cyc});
    end

    // Global time limit so the run can never hang.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    function automatic int nd_of(input int sel);
        return (sel != 0) ? 7 : 8;
    endfunction

    function automatic int np_of(input int sel);
        return (sel != 0) ? 1 : 0;
    endfunction

    function automatic int ns_of(input int sel);
        return (sel != 0) ? 2 : 1;
    endfunction

    // Reference model: outcome of one frame from its transmitted bit values.
    function automatic dv_rec_t model(input int sel, input logic [8:0] data,
                                      input logic pbit, input logic [1:0] stops);
        dv_rec_t    r;
        int         pmode = (sel != 0) ? 2 : 0;
        int         ones;
        int         lows = 0;
        logic [8:0] dm;
        dm   = data & 9'((1 << nd_of(sel)) - 1);
        ones = $countones(dm) + ((pmode != 0) ? int'(pbit) : 0);
        for (int i = 0; i < ns_of(sel); i++) if (!stops[i]) lows++;
        r.data = dm;
        r.perr = (pmode == 1) ? (ones % 2 == 0) : (pmode == 2) ? (ones % 2 == 1) : 1'b0;
        r.ferr = (lows > 0);
        r.brk  = (ones == 0) && (lows == ns_of(sel));
        r.t    = 0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Send one full frame LSB first, then idle high for two bit times.
    task automatic applyStimulus(input int sel, input logic [8:0] data, input logic pbit,
                                 input logic [1:0] stops, output int t0);
        t0 = cyc;
        set_line(sel, 1'b0);
        wait_cycles(C);
        for (int i = 0; i < nd_of(sel); i++) begin
            set_line(sel, data[i]);
            wait_cycles(C);
        end
        if (np_of(sel) != 0) begin
            set_line(sel, pbit);
            wait_cycles(C);
        end
        for (int i = 0; i < ns_of(sel); i++) begin
            set_line(sel, stops[i]);
            wait_cycles(C);
        end
        set_line(sel, 1'b1);
        wait_cycles(2 * C);
    endtask

    // DV is due 2 + H + N*C cycles after the first edge that sees the low line (t0+1).
    function automatic int dv_time(input int sel, input int t0);
        return (t0 + 1) + 2 + H + (nd_of(sel) + np_of(sel) + ns_of(sel)) * C;
    endfunction

    // Compare the DV records collected for one DUT against one expected frame.
    task automatic verify(input int sel, input string name, input dv_rec_t exp_r, input int t_exp);
        dv_rec_t q[$];
        if (sel == 0) begin q = rec_a; rec_a.delete(); end
        else          begin q = rec_b; rec_b.delete(); end
        checkOutput({name, " dv_count"}, 32'(q.size()), 32'd1);
        if (q.size() > 0) begin
            checkOutput({name, " byte"}, 32'(q[0].data), 32'(exp_r.data));
            checkOutput({name, " parity_err"}, 32'(q[0].perr), 32'(exp_r.perr));
            checkOutput({name, " frame_err"}, 32'(q[0].ferr), 32'(exp_r.ferr));
            checkOutput({name, " break"}, 32'(q[0].brk), 32'(exp_r.brk));
            if (t_exp >= 0) checkOutput({name, " dv_cycle"}, 32'(q[0].t), 32'(t_exp));
        end
    endtask

    vec_t    vecs[9];
    dv_rec_t exp_r;
    int      t0;

    initial begin
        vecs[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 9'h055, 1'b1, 2'b11, 9'h055, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{0, 9'h081, 1'b0, 2'b11, 9'h081, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h02A, 1'b1, 2'b11, 9'h02A, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h000, 1'b0, 2'b01, 9'h000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1, 9'h000, 1'b0, 2'b00, 9'h000, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1, 9'h000, 1'b1, 2'b00, 9'h000, 1'b1, 1'b1, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        wait_cycles(3);
        checkOutput("reset dv", 32'(dv_a), 32'd0);
        checkOutput("reset byte", 32'(byte_a), 32'd0);
        checkOutput("reset flags", 32'({perr_a, ferr_a, brk_a}), 32'd0);
        checkOutput("reset busy_a", 32'(busy_a), 32'd0);
        checkOutput("reset busy_b", 32'(busy_b), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        wait_cycles(3);

        // Directed table of frames, including parity, framing and break boundaries.
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].sel, vecs[v].data, vecs[v].pbit, vecs[v].stops, t0);
            exp_r = '{vecs[v].exp_byte, vecs[v].exp_perr, vecs[v].exp_ferr, vecs[v].exp_brk, 0};
            verify(vecs[v].sel, $sformatf("vec%0d", v), exp_r, dv_time(vecs[v].sel, t0));
        end

        // Line held low for 40 bit times: one DV flagged as break, busy until release.
        t0 = cyc;
        set_line(0, 1'b0);
        wait_cycles(40 * C);
        checkOutput("break busy_held", 32'(busy_a), 32'd1);
        set_line(0, 1'b1);
        wait_cycles(5);
        checkOutput("break busy_released", 32'(busy_a), 32'd0);
        wait_cycles(2 * C);
        verify(0, "break", '{9'h000, 1'b0, 1'b1, 1'b1, 0}, dv_time(0, t0));

        // Randomised frames against the reference model.
        for (int n = 0; n < 24; n++) begin
            int         sel;
            logic [8:0] d;
            logic       p;
            logic [1:0] s;
            sel = int'($urandom_range(0, 1));
            d   = ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom);
            p   = 1'($urandom);
            s   = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
            applyStimulus(sel, d, p, s, t0);
            verify(sel, $sformatf("rand%0d", n), model(sel, d, p, s), dv_time(sel, t0));
        end

        // Short low glitch: START must reject it without a DV.
        set_line(0, 1'b0);
        wait_cycles(4);
        checkOutput("glitch busy_during", 32'(busy_a), 32'd1);
        wait_cycles(1);
        set_line(0, 1'b1);
        wait_cycles(3 * C);
        checkOutput("glitch dv_count", 32'(rec_a.size()), 32'd0);
        checkOutput("glitch busy_after", 32'(busy_a), 32'd0);

        // Leave non-zero outputs, then reset in the middle of frame 0xFF.
        applyStimulus(0, 9'h03C, 1'b0, 2'b10, t0);
        verify(0, "pre_reset", '{9'h03C, 1'b0, 1'b1, 1'b0, 0}, dv_time(0, t0));
        set_line(0, 1'b0);
        wait_cycles(C);
        set_line(0, 1'b1);
        wait_cycles(3 * C);
        checkOutput("midreset busy_before", 32'(busy_a), 32'd1);
        rst_a = 1'b1;
        wait_cycles(1);
        rst_a = 1'b0;
        checkOutput("midreset busy", 32'(busy_a), 32'd0);
        checkOutput("midreset byte", 32'(byte_a), 32'd0);
        checkOutput("midreset flags", 32'({perr_a, ferr_a, brk_a}), 32'd0);
        checkOutput("midreset dv", 32'(dv_a), 32'd0);
        wait_cycles(8 * C);
        checkOutput("midreset dv_count", 32'(rec_a.size()), 32'd0);
        applyStimulus(0, 9'h012, 1'b0, 2'b11, t0);
        verify(0, "post_reset", '{9'h012, 1'b0, 1'b0, 1'b0, 0}, dv_time(0, t0));

        // One-cycle inverted spike landing exactly on each data-bit sample point of 0x96.
        begin
            logic [7:0] sd;
            sd = 8'h96;
            t0 = cyc;
            set_line(0, 1'b0);
            wait_cycles(C);
            for (int i = 0; i < 8; i++) begin
                set_line(0, sd[i]);
                wait_cycles(H);
                set_line(0, ~sd[i]);
                wait_cycles(1);
                set_line(0, sd[i]);
                wait_cycles(C - H - 1);
            end
            set_line(0, 1'b1);
            wait_cycles(3 * C);
`ifdef UART_RX_MAJORITY_EN
            verify(0, "spike", '{9'h096, 1'b0, 1'b0, 1'b0, 0}, dv_time(0, t0));
`else
            verify(0, "spike", '{9'h069, 1'b0, 1'b0, 1'b0, 0}, dv_time(0, t0));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports 5–9 data bits, none/odd/even parity, and 1 or 2 stop bits. Reports parity errors, framing errors and line-break conditions. Sits between the board RX pin and the message/FIFO logic in the same i_Clock domain.

Parameters:
- CLKS_PER_BIT, 5208, i_Clock cycles per bit (50 MHz / 9600 baud); legal range 4 or more.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  asynchronous serial line; idles high.
- o_Rx_DV  out  1  one-cycle pulse: frame complete, o_Rx_Byte and flags valid.
- o_Rx_Byte  out  DATA_BITS  received data, LSB first on the wire.
- o_Parity_Err  out  1  parity mismatch in the last frame (0 when PARITY=0).
- o_Frame_Err  out  1  a stop bit sampled low in the last frame.
- o_Break  out  1  last frame was all-zero, including parity and stop bits.
- o_Busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset: one clock domain (i_Clock). Reset is synchronous, active-high, on i_Reset.
- Input sync: two-flop synchroniser on i_Rx_Serial, both flops reset to 1. All sampling uses the second flop.
- Counters:
  - Clock counter width is $clog2(CLKS_PER_BIT)+1.
  - Bit index width is 4.
- States: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_IDLE.
- IDLE:
  - Counter and index cleared, o_Rx_DV=0.
  - Synced line = 0 → START.
- START:
  - Count to (CLKS_PER_BIT-1)/2, then sample.
  - Sample 0 → clear counter, go to DATA.
  - Sample 1 → glitch: return to IDLE with no flags and no DV.
- DATA:
  - Each bit is sampled when the counter reaches CLKS_PER_BIT-1; the counter then clears. Bit spacing is exactly CLKS_PER_BIT cycles.
  - Sample is written to o_Rx_Byte[index].
  - After bit DATA_BITS-1: go to PARITY if PARITY≠0, else STOP.
- PARITY:
  - One bit period, then sample.
  - Error when XOR(data, parity bit) = 0 for odd, or = 1 for even.
- STOP:
  - STOP_BITS periods; each stop bit is sampled at its mid-bit point.
  - Any low stop sample sets the frame error.
  - At the final stop sample: pulse o_Rx_DV for 1 cycle and update all three flags in the same cycle.
  - No framing error → CLEANUP. Framing error → WAIT_IDLE.
- CLEANUP: one cycle, o_Rx_DV=0, → IDLE.
- WAIT_IDLE: stay until synced line = 1, then → IDLE. A held-low break therefore produces exactly one DV.
- o_Break: set when all data bits, the parity bit (if present) and all stop bits sampled 0. It always coincides with o_Frame_Err=1.
- Flag persistence: o_Rx_Byte and the three flags hold until the next o_Rx_DV. They are meaningful only when qualified by o_Rx_DV.
- Latency: o_Rx_DV rises 2 (synchroniser) + (CLKS_PER_BIT-1)/2 + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT cycles after the falling start edge, where P=1 if parity is enabled, else 0.
- Back-to-back frames: a start edge arriving during CLEANUP is caught in IDLE on the next cycle. The resulting offset is at most 2 cycles and stays within the mid-bit margin.
- Reset mid-frame:
  - Return to IDLE; no DV is emitted.
  - o_Rx_Byte=0, all flags=0, o_Busy=0, synchroniser flops=1.
  - A frame already in flight on the line is resynchronised on its next falling edge. Data bits seen as edges may produce a garbage frame; this is accepted.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - A 3-bit shift register of synced samples runs every cycle.
  - Every sample point (start, data, parity, stop) uses the 2-of-3 majority of the last three synced samples.
  - Timing and latency are unchanged.
  - Requires CLKS_PER_BIT ≥ 6.
- Undefined: single synced sample at each sample point. No shift register is instantiated.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5 → o_Rx_DV pulses once, o_Rx_Byte=0xA5, all flags 0, DV timing matches the latency formula.
- DATA_BITS=7, PARITY=2 (even), STOP_BITS=2, send 0x55 with parity bit 1 (wrong) → o_Rx_Byte=0x55, o_Parity_Err=1, o_Frame_Err=0.
- 8N1, send 0x3C with stop bit forced 0, then line high → o_Frame_Err=1, o_Break=0, FSM passes WAIT_IDLE, next frame 0x81 received cleanly with all flags 0.
- 8N1, hold line low for 40 bit times → exactly one o_Rx_DV with o_Rx_Byte=0x00, o_Break=1, o_Frame_Err=1; o_Busy stays high until the line rises.
- Low glitch of 5 cycles (shorter than (CLKS_PER_BIT-1)/2=7) → return to IDLE, no o_Rx_DV. Then assert i_Reset for 1 cycle mid-way through frame 0xFF → no DV, all outputs 0, following frame 0x12 received correctly.
- With UART_RX_MAJORITY_EN: 1-cycle inverted spike exactly at each data-bit sample point of 0x96 → o_Rx_Byte=0x96, flags 0. Without the macro the same stimulus corrupts the byte (checks that the compile switch is effective).
